// File: rtl/cluster_clk_gate.sv
// Latch-based cluster clock gate with enable hold-off and activity counters.
// Define CLK_GATE_BYPASS_EN for a latch-free, always-running FPGA variant.
module cluster_clk_gate #(
  parameter int HOLD_CYCLES = 0,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 test_en_i,
  output logic                 clk_o,
  output logic                 clk_en_o,
  output logic [CNT_WIDTH-1:0] active_cycles_o,
  output logic [CNT_WIDTH-1:0] gated_cycles_o
);

  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  logic hold_nz;
  logic en_eff;
  logic gate;
  logic [CNT_WIDTH-1:0] act_q;
  logic [CNT_WIDTH-1:0] gat_q;

  generate
    if (HOLD_CYCLES > 0) begin : g_hold
      logic [HW-1:0] hold_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_q <= '0;
        end else if (en_i) begin
          hold_q <= HW'(HOLD_CYCLES);
        end else if (hold_q != '0) begin
          hold_q <= hold_q - HW'(1);
        end
      end

      assign hold_nz = (hold_q != '0);
    end else begin : g_nohold
      assign hold_nz = 1'b0;
    end
  endgenerate

  assign en_eff = en_i | test_en_i | hold_nz;

`ifdef CLK_GATE_BYPASS_EN
  logic en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= 1'b0;
    end else begin
      en_q <= en_eff;
    end
  end

  assign gate     = en_q;
  assign clk_o    = clk;
  assign clk_en_o = 1'b1;
`else
  logic en_lat;

  // Transparent only in the low phase, so clk_o never sees a runt.
  always_latch begin
    if (!rst_n) begin
      en_lat = test_en_i;
    end else if (!clk) begin
      en_lat = en_eff;
    end
  end

  assign gate     = en_lat;
  assign clk_o    = clk & en_lat;
  assign clk_en_o = en_lat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= '0;
      gat_q <= '0;
    end else if (gate) begin
      if (act_q != '1) begin
        act_q <= act_q + CNT_WIDTH'(1);
      end
    end else begin
      if (gat_q != '1) begin
        gat_q <= gat_q + CNT_WIDTH'(1);
      end
    end
  end

  assign active_cycles_o = act_q;
  assign gated_cycles_o  = gat_q;

endmodule

// File: tb/tb_cluster_clk_gate.sv
// Directed bench for cluster_clk_gate: three instances cover
// HOLD_CYCLES=0, HOLD_CYCLES=3 and a 4-bit saturating counter.
module tb_cluster_clk_gate;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_i = 1'b1;
  logic test_en_i = 1'b0;

  logic        c0, e0, c3, e3, cw, ew;
  logic [31:0] a0, g0, a3, g3;
  logic [3:0]  aw, gw;

  int n_cmp = 0;
  int n_bad = 0;
  int p0 = 0;
  int p3 = 0;
  int bad_w = 0;
  time rise0 = 0;

  always #5 clk = ~clk;

  cluster_clk_gate #(.HOLD_CYCLES(0), .CNT_WIDTH(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .test_en_i(test_en_i),
    .clk_o(c0), .clk_en_o(e0),
    .active_cycles_o(a0), .gated_cycles_o(g0)
  );

  cluster_clk_gate #(.HOLD_CYCLES(3), .CNT_WIDTH(32)) dut3 (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .test_en_i(test_en_i),
    .clk_o(c3), .clk_en_o(e3),
    .active_cycles_o(a3), .gated_cycles_o(g3)
  );

  cluster_clk_gate #(.HOLD_CYCLES(0), .CNT_WIDTH(4)) dutw (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .test_en_i(test_en_i),
    .clk_o(cw), .clk_en_o(ew),
    .active_cycles_o(aw), .gated_cycles_o(gw)
  );

  always @(posedge c0) begin
    p0++;
    rise0 = $time;
  end

  always @(negedge c0) begin
    if ($time - rise0 != 5) bad_w++;
  end

  always @(posedge c3) p3++;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic en;
    logic ten;
    int   act;
    int   gat;
  } vec_t;

  vec_t tbl[25];
  int   b0, b3;

  initial begin
    for (int i = 0; i < 10; i++) tbl[i] = '{1'b1, 1'b0, i + 1, 0};
    for (int i = 0; i < 5; i++) tbl[10 + i] = '{1'b0, 1'b0, 10, i + 1};
    for (int i = 0; i < 2; i++) tbl[15 + i] = '{1'b1, 1'b0, 11 + i, 5};
    for (int i = 0; i < 8; i++) tbl[17 + i] = '{1'b0, 1'b1, 13 + i, 5};

    // Reset with en_i=1, test_en_i=0: gate held closed
    repeat (3) @(posedge clk);
    #1;
    chk("rst_act", a0, 0);
    chk("rst_gat", g0, 0);
    chk("rst_clk_en", e0, 0);
    chk("rst_pulses", p0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      en_i = tbl[i].en;
      test_en_i = tbl[i].ten;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_act", i), a0, tbl[i].act);
      chk($sformatf("vec%0d_gat", i), g0, tbl[i].gat);
      chk($sformatf("vec%0d_pulses", i), p0, tbl[i].act);
    end
    chk("hold3_act", a3, 23);
    chk("hold3_gat", g3, 2);
    chk("w4_sat_act", aw, 15);
    chk("w4_gat", gw, 5);

    // One-cycle enable pulse with HOLD_CYCLES=3 -> 4 edges
    en_i = 1'b0;
    test_en_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    b0 = p0;
    b3 = p3;
    en_i = 1'b1;
    @(posedge clk);
    #1;
    en_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_4th_edge_en", e3, 1);
    chk("hold_4_edges", p3 - b3, 4);
    @(negedge clk);
    #1;
    chk("hold_en_fall", e3, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_stopped", p3 - b3, 4);
    chk("nohold_1_edge", p0 - b0, 1);

    // en_i glitch 0->1->0 inside a high phase
    b0 = p0;
    en_i = 1'b1;
    #1;
    chk("glitch0_en_a", e0, 0);
    chk("glitch0_clk", c0, 0);
    en_i = 1'b0;
    #1;
    chk("glitch0_en_b", e0, 0);
    @(posedge clk);
    #1;
    chk("glitch0_pulses", p0, b0);

    // en_i glitch 1->0->1 inside a high phase while gate open
    en_i = 1'b1;
    @(posedge clk);
    #1;
    en_i = 1'b0;
    #1;
    chk("glitch1_clk_a", c0, 1);
    en_i = 1'b1;
    #1;
    chk("glitch1_clk_b", c0, 1);
    chk("glitch1_en", e0, 1);

    // Reset in low phase with test_en_i=1: clock runs, counters clear
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    test_en_i = 1'b1;
    en_i = 1'b0;
    #1;
    chk("rstmid_act", a0, 0);
    chk("rstmid_w4_act", aw, 0);
    chk("rstmid_w4_gat", gw, 0);
    chk("rstmid_hold_act", a3, 0);
    chk("rstmid_clk_en", e0, 1);
    b0 = p0;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_test_pulses", p0 - b0, 8);
    chk("rst_test_act", a0, 0);
    chk("rst_test_gat", g0, 0);
    chk("pulse_width", bad_w, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
